shift_pattern_det: RTL and testbench
====================================

Name: shift_pattern_det

Overview:
- Downstream consumer of the 3-bit serial-in/parallel-out shift register.
- Watches the parallel window q on every qualified shift and compares it against a programmable pattern.
- On a hit, emits a one-cycle match pulse and keeps a saturating match counter plus a sticky overflow flag.
- Handles the post-reset warm-up, so a partially filled register never produces a false hit, and supports an optional non-overlapping detection mode.

Parameters:
- W, 3: window width; must equal the shift register width.
- CW, 8: match counter width.
- OVERLAP, 1: 1 = overlapping matches counted; 0 = after a hit, the next W-1 shifts are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- q  in  W  shift register window; q[0] is the newest bit, q[W-1] the oldest.
- shift_en  in  1  high in a cycle whose q holds a freshly shifted window. Tie to 1 when the register shifts every clock.
- pattern  in  W  pattern value to load.
- pattern_load  in  1  load pattern into pat_reg.
- clr  in  1  clear match_cnt and ovf.
- match  out  1  one-cycle pulse, registered.
- match_cnt  out  CW  saturating count of matches.
- ovf  out  1  sticky; set when a match arrives while match_cnt is all ones.
- armed  out  1  high when the FSM is in ARMED.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs are 0. Reset values are state=WARM, fill=0, pat_reg=0, match=0, match_cnt=0, ovf=0, armed=0. Reset mid-operation aborts everything, including a HOLD, and behaves identically to the initial reset.
- fill: counter 0..W-1, width clog2(W)+1. It increments only on shift_en; cycles without shift_en change nothing except load/clr.
- WARM state: no compare. On shift_en with fill==W-1, go to ARMED and clear fill. The W-th shift after reset is NOT compared; the first compare happens on the (W+1)-th shift.
  - Consequence: the window counts only after W real bits have entered. With W=3, the first window compared holds shifted bits 1..3 and is presented on the 4th shift_en (the register's own 1-cycle latency).
- ARMED state: on shift_en, compare q==pat_reg.
  - Equal: match is 1 in the next cycle (latency 1), and match_cnt increments, saturating at 2^CW-1.
  - Equal while match_cnt is already all ones: ovf is set and match_cnt holds.
  - Equal with OVERLAP=0: go to HOLD with fill=0.
- HOLD state (OVERLAP=0 only): on shift_en, fill increments with no compare. When fill==W-2 on shift_en, return to ARMED. Exactly W-1 shifts are skipped; for W=2 the FSM returns after one shift.
- match: high for exactly one cycle per hit. Back-to-back hits on consecutive shift_en cycles (OVERLAP=1) keep match high on each of those cycles.
- pattern_load: pat_reg <= pattern at the edge. A compare in the same cycle uses the old pat_reg. FSM state and fill are unaffected.
- clr: match_cnt <= 0 and ovf <= 0.
  - clr together with a hit: clr wins for match_cnt and ovf (result 0), but the match pulse is still emitted.
  - clr together with rst: rst wins.
- armed: equals (state==ARMED), registered with the state.
- shift_en low in ARMED: no compare; match goes to 0 the following cycle.

Decomposition:
- Shared package: state encoding (WARM=2'd0, ARMED=2'd1, HOLD=2'd2) and the default widths W=3 and CW=8. The package is also used by the shift register bench.
- One natural sub-module, sat_counter (CW-bit, inc/clr, saturate, ovf). Everything else (FSM, compare, pattern register) stays in shift_pattern_det.

Test Plan:
1. Warm-up: rst for 5 cycles, then shift_en=1 with q sequence 001, 011, 111 and pattern 111 loaded. No match during the three warm-up shifts, armed rises after the 3rd shift. q=111 on the 4th shift -> match=1 one cycle later, match_cnt=1.
2. Overlap, OVERLAP=1, pattern 101, armed: q sequence 101, 010, 101, 010, 100, 001, 010 -> match pulses after the 1st and 3rd windows only, match_cnt=2.
3. Non-overlap, OVERLAP=0, same sequence as scenario 2 -> single match after the 1st window. The 3rd window (101) falls inside HOLD and is ignored, so match_cnt=1.
4. Saturation, CW=2, pattern 000, armed: q=000 held with shift_en=1 for 5 shifts -> match_cnt reaches 3 after 3 hits and holds, ovf=1 after the 4th hit. clr -> match_cnt=0, ovf=0.
5. Simultaneous events: pattern_load with a new pattern (110) in the same cycle as a q window equal to the old pattern -> the old pattern matches. The next q=110 matches the new pattern. clr in the same cycle as a hit -> match=1 but match_cnt=0.
6. Reset mid-HOLD (OVERLAP=0): assert rst one cycle after a match -> all outputs 0, state WARM. The next three shifts produce no match even when q equals pattern.

Source files
------------

// File: rtl/shift_pattern_det_pkg.sv
// Shared definitions for the shift-register pattern detector and its companions:
// FSM state encoding and default widths.
package shift_pattern_det_pkg;

   typedef enum logic [1:0] {
      ST_WARM  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int DEF_W  = 3;
   localparam int DEF_CW = 8;

endpackage

// File: rtl/shift_pattern_det_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear has priority over increment.
module sat_counter
   import shift_pattern_det_pkg::*;
#(
   parameter int CW = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_inc,
   input  logic          i_clr,
   output logic [CW-1:0] o_cnt,
   output logic          o_ovf
);

   logic [CW-1:0] r_cnt;
   logic          r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_inc) begin
         // A hit on a full counter only raises the sticky flag.
         if (&r_cnt) r_ovf <= 1'b1;
         else        r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_ovf = r_ovf;

endmodule

// File: rtl/shift_pattern_det.sv
// Compares each freshly shifted window of a SIPO register against a programmable
// pattern, with post-reset warm-up and optional non-overlapping detection.
module shift_pattern_det
   import shift_pattern_det_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int CW      = DEF_CW,
   parameter int OVERLAP = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  q,
   input  logic          shift_en,
   input  logic [W-1:0]  pattern,
   input  logic          pattern_load,
   input  logic          clr,
   output logic          match,
   output logic [CW-1:0] match_cnt,
   output logic          ovf,
   output logic          armed
);

   localparam int             FW             = $clog2(W) + 1;
   localparam logic [FW-1:0]  FILL_WARM_LAST = FW'(W - 1);
   localparam logic [FW-1:0]  FILL_HOLD_LAST = FW'(W - 2);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [FW-1:0] r_fill;
   logic [FW-1:0] w_fill_nxt;
   logic [W-1:0]  r_pat;
   logic          r_match;
   logic          w_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_WARM;
         r_fill  <= '0;
         r_pat   <= '0;
         r_match <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fill  <= w_fill_nxt;
         r_match <= w_hit;
         // A compare in this same cycle still sees the previous pattern.
         if (pattern_load) r_pat <= pattern;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_hit       = 1'b0;
      case (r_state)
         ST_WARM: begin
            // The W-th shift only completes the fill; it is not compared.
            if (shift_en) begin
               if (r_fill == FILL_WARM_LAST) begin
                  w_state_nxt = ST_ARMED;
                  w_fill_nxt  = '0;
               end else begin
                  w_fill_nxt  = r_fill + FW'(1);
               end
            end
         end
         ST_ARMED: begin
            if (shift_en && (q == r_pat)) begin
               w_hit = 1'b1;
               if (OVERLAP == 0) begin
                  w_state_nxt = ST_HOLD;
                  w_fill_nxt  = '0;
               end
            end
         end
         ST_HOLD: begin
            // Skip exactly W-1 shifts so no bit of the matched window is reused.
            if (shift_en) begin
               if (r_fill == FILL_HOLD_LAST) begin
                  w_state_nxt = ST_ARMED;
                  w_fill_nxt  = '0;
               end else begin
                  w_fill_nxt  = r_fill + FW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_WARM;
            w_fill_nxt  = '0;
         end
      endcase
   end

   sat_counter #(
      .CW (CW)
   ) u_sat_counter (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_hit),
      .i_clr (clr),
      .o_cnt (match_cnt),
      .o_ovf (ovf)
   );

   assign match = r_match;
   assign armed = (r_state == ST_ARMED);

endmodule

// File: tb/tb_shift_pattern_det.sv
// Directed bench for shift_pattern_det: three instances (overlapping, non-overlapping,
// 2-bit counter) share one stimulus stream; each scenario checks the relevant one.
module tb_shift_pattern_det;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] q;
   logic       shift_en;
   logic [2:0] pattern;
   logic       pattern_load;
   logic       clr;

   logic       match_a, ovf_a, armed_a;
   logic [7:0] cnt_a;
   logic       match_b, ovf_b, armed_b;
   logic [7:0] cnt_b;
   logic       match_c, ovf_c, armed_c;
   logic [1:0] cnt_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   shift_pattern_det #(.W(3), .CW(8), .OVERLAP(1)) u_dut_a (
      .clk(clk), .rst(rst), .q(q), .shift_en(shift_en), .pattern(pattern),
      .pattern_load(pattern_load), .clr(clr), .match(match_a), .match_cnt(cnt_a),
      .ovf(ovf_a), .armed(armed_a));

   shift_pattern_det #(.W(3), .CW(8), .OVERLAP(0)) u_dut_b (
      .clk(clk), .rst(rst), .q(q), .shift_en(shift_en), .pattern(pattern),
      .pattern_load(pattern_load), .clr(clr), .match(match_b), .match_cnt(cnt_b),
      .ovf(ovf_b), .armed(armed_b));

   shift_pattern_det #(.W(3), .CW(2), .OVERLAP(1)) u_dut_c (
      .clk(clk), .rst(rst), .q(q), .shift_en(shift_en), .pattern(pattern),
      .pattern_load(pattern_load), .clr(clr), .match(match_c), .match_cnt(cnt_c),
      .ovf(ovf_c), .armed(armed_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift(input logic [2:0] v);
      q        = v;
      shift_en = 1'b1;
      tick();
   endtask

   // Reset, load the pattern and push three non-matching warm-up windows.
   task automatic warmup(input logic [2:0] p);
      rst = 1'b1;
      shift_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      pattern = p;
      pattern_load = 1'b1;
      for (int i = 0; i < 3; i++) shift(~p);
      pattern_load = 1'b0;
      shift_en = 1'b0;
   endtask

   initial begin
      logic [2:0] seq [7];
      logic       exp_a [7];
      logic       exp_b [7];
      logic [1:0] exp_cc [5];
      logic       exp_co [5];

      rst = 1'b1; q = '0; shift_en = 1'b0; pattern = '0; pattern_load = 1'b0; clr = 1'b0;

      // 1: reset and warm-up
      for (int i = 0; i < 5; i++) tick();
      check("rst_match", match_a, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_armed", armed_a, 0);
      rst = 1'b0;
      pattern = 3'b111; pattern_load = 1'b1;
      tick();
      pattern_load = 1'b0;
      shift(3'b001);
      check("warm1_match", match_a, 0);
      check("warm1_armed", armed_a, 0);
      shift(3'b011);
      check("warm2_match", match_a, 0);
      check("warm2_armed", armed_a, 0);
      shift(3'b111);
      check("warm3_match", match_a, 0);
      check("warm3_armed", armed_a, 1);
      shift(3'b111);
      check("first_hit_match", match_a, 1);
      check("first_hit_cnt", cnt_a, 1);
      shift_en = 1'b0;
      tick();
      check("idle_match", match_a, 0);
      check("idle_cnt", cnt_a, 1);

      // 2 + 3: overlapping (A) vs non-overlapping (B) on the same stream
      warmup(3'b101);
      check("ov_armed_a", armed_a, 1);
      check("ov_armed_b", armed_b, 1);
      seq   = '{3'b101, 3'b010, 3'b101, 3'b010, 3'b100, 3'b001, 3'b010};
      exp_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         shift(seq[i]);
         check($sformatf("ov_match_a[%0d]", i), match_a, exp_a[i]);
         check($sformatf("nov_match_b[%0d]", i), match_b, exp_b[i]);
         if (i == 0) check("nov_hold_armed_b", armed_b, 0);
      end
      check("ov_cnt_a", cnt_a, 2);
      check("nov_cnt_b", cnt_b, 1);
      check("nov_rearmed_b", armed_b, 1);

      // 4: saturation on the 2-bit counter
      warmup(3'b000);
      exp_cc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      exp_co = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         shift(3'b000);
         check($sformatf("sat_match[%0d]", i), match_c, 1);
         check($sformatf("sat_cnt[%0d]", i), cnt_c, exp_cc[i]);
         check($sformatf("sat_ovf[%0d]", i), ovf_c, exp_co[i]);
      end
      shift_en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      check("sat_clr_cnt", cnt_c, 0);
      check("sat_clr_ovf", ovf_c, 0);

      // 5: pattern load and clr colliding with hits
      warmup(3'b011);
      pattern = 3'b110; pattern_load = 1'b1;
      shift(3'b011);
      pattern_load = 1'b0;
      check("ld_old_pat_match", match_a, 1);
      check("ld_old_pat_cnt", cnt_a, 1);
      shift(3'b110);
      check("ld_new_pat_match", match_a, 1);
      check("ld_new_pat_cnt", cnt_a, 2);
      clr = 1'b1;
      shift(3'b110);
      clr = 1'b0;
      check("clr_hit_match", match_a, 1);
      check("clr_hit_cnt", cnt_a, 0);
      shift(3'b011);
      check("after_clr_match", match_a, 0);
      check("after_clr_cnt", cnt_a, 0);

      // 6: reset while B is in HOLD
      warmup(3'b101);
      shift(3'b101);
      check("pre_rst_match_b", match_b, 1);
      check("pre_rst_armed_b", armed_b, 0);
      rst = 1'b1;
      shift(3'b101);
      check("mid_rst_match_b", match_b, 0);
      check("mid_rst_cnt_b", cnt_b, 0);
      check("mid_rst_ovf_b", ovf_b, 0);
      check("mid_rst_armed_b", armed_b, 0);
      rst = 1'b0;
      pattern = 3'b101; pattern_load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         shift(3'b101);
         pattern_load = 1'b0;
         check($sformatf("post_rst_match_b[%0d]", i), match_b, 0);
      end
      check("post_rst_armed_b", armed_b, 1);
      shift(3'b101);
      check("post_rst_hit_b", match_b, 1);
      check("post_rst_cnt_b", cnt_b, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
